dual_input_debouncer: RTL and testbench
=======================================

Name: dual_input_debouncer

Overview:
- Conditions two raw switch/pushbutton inputs into clean, glitch-free, registered logic levels.
- Those levels drive the A and B inputs of the downstream 2-input gate stage in the Part 1 lab top level.
- Each channel has an independent filter state machine and hold counter.
- Each channel emits a one-cycle change pulse when its committed level flips.

Parameters:
- DB_CYCLES, 16: consecutive sampling edges a raw level must persist before it is committed. Legal range 2 to 2^CNT_W - 1. Board builds override to 500000.
- CNT_W, 5: hold counter width; must satisfy 2^CNT_W > DB_CYCLES. Board builds use 19.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst  input  1  asynchronous, active-high reset.
- Ain  input  1  raw, bouncy input for channel A.
- Bin  input  1  raw, bouncy input for channel B.
- A  output  1  debounced, registered level for channel A; feeds downstream gate input A.
- B  output  1  debounced, registered level for channel B; feeds downstream gate input B.
- AChg  output  1  one-cycle pulse when A changes.
- BChg  output  1  one-cycle pulse when B changes.

Behaviour:
- One clock domain (Clk). Reset is asynchronous and active-high (Rst).
- Reset values, applied immediately on Rst assertion with no clock needed:
  - A=0, B=0, AChg=0, BChg=0.
  - Both channels in STABLE_LO with counter=0.
  - Synchronizer flops (if present) = 0.
- Rst assertion mid-filter aborts any pending change; the partial count is discarded.
- On Rst deassertion, channels start from STABLE_LO on the next rising edge. A raw input already high is then filtered normally and commits after DB_CYCLES edges.
- Per-channel state machine (two copies, A and B identical and fully independent). "s" is the sampled raw input.
  - STABLE_LO (out=0):
    - s=1 -> WAIT_HI, cnt<=1.
    - else stay, cnt<=0.
  - WAIT_HI (out=0):
    - s=0 -> STABLE_LO, cnt<=0 (bounce rejected).
    - s=1 and cnt==DB_CYCLES-1 -> STABLE_HI, out<=1, chg<=1, cnt<=0.
    - s=1 otherwise -> cnt<=cnt+1.
  - STABLE_HI / WAIT_LO: mirror images of the above with the polarities swapped.
- chg is high for exactly one cycle, the cycle after the commit edge; it is 0 in all other cycles.
- Latency without synchronizer:
  - If the first edge sampling a new value is edge k and the value holds, out changes after edge k+DB_CYCLES-1.
  - The value must therefore be seen on DB_CYCLES consecutive edges.
- Any reversion before the count completes restarts filtering from zero. Continuous bounce never commits.
- Simultaneous A and B changes are handled independently; both may commit on the same edge.
- Counter never exceeds DB_CYCLES-1, so there is no wrap-around.
- Outputs A and B are registered and never combinationally dependent on Ain or Bin.

Optional Feature:
- Macro: DEBOUNCE_SYNC_EN
- Defined:
  - Each raw input passes through a 2-flop synchronizer (reset to 0) before the state machine.
  - s is the second flop's output.
  - Commit latency grows by exactly 2 edges, to k+DB_CYCLES+1.
  - Required for asynchronous board switches.
- Undefined:
  - s is the raw input sampled directly.
  - Latency is as stated in Behaviour.
  - Intended for simulation and for already-synchronous sources.

Test Plan (DB_CYCLES=4, DEBOUNCE_SYNC_EN undefined unless noted):
- Reset: raise Rst between clock edges with Ain=Bin=1 -> A=B=AChg=BChg=0 immediately. After release and Ain held 1, A=1 after the 4th edge, with AChg=1 for one cycle.
- Bounce reject: Ain pattern 1,1,0,1,1,0 over six edges -> A stays 0, AChg never pulses.
- Clean press/release: Ain=1 for 6 edges then 0 for 6 edges -> A rises after edge 4 and falls 4 edges after the release. AChg pulses twice, each exactly 1 cycle wide.
- Independence: Ain and Bin rise on the same edge, Bin glitches low at count 2 -> A commits on schedule, B commits 4 edges after its glitch ends.
- Reset mid-count: Ain=1 for 3 edges, pulse Rst, Ain held 1 -> A commits only after 4 further edges following Rst release.
- DEBOUNCE_SYNC_EN defined: Ain held 1 -> A rises after edge 6 (first sampling edge counted as 1).

Source files
------------

// File: rtl/dual_input_debouncer.sv
// Two-channel switch debouncer. It turns raw, bouncy Ain/Bin into clean,
// registered levels A/B for the downstream 2-input gate stage. Each channel
// has its own filter FSM and hold counter. Each channel also pulses *Chg for
// one cycle whenever its committed level flips.
//
// Optional build macro: DEBOUNCE_SYNC_EN
//   When defined, each raw input first passes through a 2-flop synchronizer
//   (reset to 0). This adds exactly 2 edges of commit latency.
//
// Ports:
//   Clk   in   system clock, rising edge
//   Rst   in   asynchronous, active-high reset
//   Ain   in   raw input, channel A
//   Bin   in   raw input, channel B
//   A     out  debounced level, channel A
//   B     out  debounced level, channel B
//   AChg  out  one-cycle pulse when A changes
//   BChg  out  one-cycle pulse when B changes
module dual_input_debouncer #(
  parameter int unsigned DB_CYCLES = 16,
  parameter int unsigned CNT_W     = 5
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Ain,
  input  logic Bin,
  output logic A,
  output logic B,
  output logic AChg,
  output logic BChg
);

  localparam int unsigned NUM_CH = 2;

  localparam logic [1:0] ST_STABLE_LO = 2'd0;
  localparam logic [1:0] ST_WAIT_HI   = 2'd1;
  localparam logic [1:0] ST_STABLE_HI = 2'd2;
  localparam logic [1:0] ST_WAIT_LO   = 2'd3;

  // Count value on the last edge of a qualifying run
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  // Channel index 0 = A, 1 = B
  logic [NUM_CH-1:0]            samp;
  logic [NUM_CH-1:0][1:0]       state_q, state_d;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]            out_q, out_d;
  logic [NUM_CH-1:0]            chg_q, chg_d;

`ifdef DEBOUNCE_SYNC_EN
  // 2-flop synchronizer for asynchronous board switches
  logic [NUM_CH-1:0] sync1_q, sync2_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {Bin, Ain};
      sync2_q <= sync1_q;
    end
  end

  assign samp = sync2_q;
`else
  assign samp = {Bin, Ain};
`endif

  // State, counter and output registers for both channels
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= {NUM_CH{ST_STABLE_LO}};
      cnt_q   <= '0;
      out_q   <= '0;
      chg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      chg_q   <= chg_d;
    end
  end

  // Per-channel filter. A reversion before the count completes returns the
  // channel to its stable state with the count cleared.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    chg_d   = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      case (state_q[ch])
        ST_STABLE_LO: begin
          if (samp[ch]) begin
            state_d[ch] = ST_WAIT_HI;
            cnt_d[ch]   = CNT_W'(1);
          end else begin
            cnt_d[ch]   = '0;
          end
        end
        ST_WAIT_HI: begin
          if (!samp[ch]) begin
            state_d[ch] = ST_STABLE_LO;
            cnt_d[ch]   = '0;
          end else if (cnt_q[ch] == CNT_LAST) begin
            state_d[ch] = ST_STABLE_HI;
            out_d[ch]   = 1'b1;
            chg_d[ch]   = 1'b1;
            cnt_d[ch]   = '0;
          end else begin
            cnt_d[ch]   = cnt_q[ch] + CNT_W'(1);
          end
        end
        ST_STABLE_HI: begin
          if (!samp[ch]) begin
            state_d[ch] = ST_WAIT_LO;
            cnt_d[ch]   = CNT_W'(1);
          end else begin
            cnt_d[ch]   = '0;
          end
        end
        ST_WAIT_LO: begin
          if (samp[ch]) begin
            state_d[ch] = ST_STABLE_HI;
            cnt_d[ch]   = '0;
          end else if (cnt_q[ch] == CNT_LAST) begin
            state_d[ch] = ST_STABLE_LO;
            out_d[ch]   = 1'b0;
            chg_d[ch]   = 1'b1;
            cnt_d[ch]   = '0;
          end else begin
            cnt_d[ch]   = cnt_q[ch] + CNT_W'(1);
          end
        end
        default: begin
          state_d[ch] = ST_STABLE_LO;
          cnt_d[ch]   = '0;
          out_d[ch]   = 1'b0;
        end
      endcase
    end
  end

  assign A    = out_q[0];
  assign B    = out_q[1];
  assign AChg = chg_q[0];
  assign BChg = chg_q[1];

endmodule

// File: tb/tb_dual_input_debouncer.sv
// Self-checking bench for dual_input_debouncer with DB_CYCLES=4.
// Expected output vectors {A,B,AChg,BChg} are queued as each edge is driven.
// Each vector is popped and compared 1 time unit after that rising edge.
module tb_dual_input_debouncer;

  localparam int unsigned DB = 4;
`ifdef DEBOUNCE_SYNC_EN
  localparam int unsigned SYNC_DLY = 2;
`else
  localparam int unsigned SYNC_DLY = 0;
`endif
  // Edge number (first sampling edge = 1) on which a held level commits
  localparam int unsigned COMMIT = DB + SYNC_DLY;

  logic Clk, Rst, Ain, Bin;
  logic A, B, AChg, BChg;

  logic [3:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  dual_input_debouncer #(.DB_CYCLES(DB), .CNT_W(5)) dut (
    .Clk(Clk), .Rst(Rst), .Ain(Ain), .Bin(Bin),
    .A(A), .B(B), .AChg(AChg), .BChg(BChg)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Called at a falling edge; holds reset across one rising edge
  task automatic do_reset(input logic a, input logic b);
    Rst = 1'b1; Ain = a; Bin = b;
    @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] got, want;
    do_reset(1'b0, 1'b0);
    // Both channels held high from a fresh reset: both commit on the same edge
    for (int i = 1; i <= 8; i++) begin
      Ain = 1'b1; Bin = 1'b1;
      exp_q.push_back({i >= COMMIT, i >= COMMIT, i == COMMIT, i == COMMIT});
      @(posedge Clk); #1;
      got = {A, B, AChg, BChg}; want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL reset_pre edge %0d got %b want %b", i, got, want);
      end
      @(negedge Clk);
    end
    // Asynchronous reset between edges clears the outputs immediately
    Rst = 1'b1;
    #1;
    got = {A, B, AChg, BChg};
    checks++;
    if (got !== 4'b0000) begin
      errors++; $display("FAIL reset_async got %b want 0000", got);
    end
    @(posedge Clk); #1;
    got = {A, B, AChg, BChg};
    checks++;
    if (got !== 4'b0000) begin
      errors++; $display("FAIL reset_hold got %b want 0000", got);
    end
    @(negedge Clk);
    Rst = 1'b0;
    // An input already high when reset is released is filtered from scratch
    for (int i = 1; i <= 8; i++) begin
      Ain = 1'b1; Bin = 1'b1;
      exp_q.push_back({i >= COMMIT, i >= COMMIT, i == COMMIT, i == COMMIT});
      @(posedge Clk); #1;
      got = {A, B, AChg, BChg}; want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL reset_post edge %0d got %b want %b", i, got, want);
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_bounce();
    logic [3:0] got, want;
    logic [0:25] pat;
    // 1,1,0,1,1,0 then continuous alternation: never reaches 4 in a row
    pat = 26'b110110_10101010101010101010;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 26; i++) begin
      Ain = pat[i]; Bin = ~pat[i];
      exp_q.push_back(4'b0000);
      @(posedge Clk); #1;
      got = {A, B, AChg, BChg}; want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL bounce edge %0d got %b want %b", i + 1, got, want);
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_press_release();
    logic [3:0] got, want;
    logic [0:13] pat;
    logic [3:0] exp_t [14];
    // Press for 6, short low glitch while high, then release
    pat = 14'b111111_001_00000;
    exp_t = '{4'b0000, 4'b0000, 4'b0000, 4'b1010, 4'b1000, 4'b1000,
              4'b1000, 4'b1000, 4'b1000,
              4'b1000, 4'b1000, 4'b1000, 4'b0010, 4'b0000};
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      Ain = pat[i]; Bin = 1'b0;
      exp_q.push_back(exp_t[i]);
      @(posedge Clk); #1;
      got = {A, B, AChg, BChg}; want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL press_release edge %0d got %b want %b", i + 1, got, want);
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_independence();
    logic [3:0] got, want;
    logic [0:8] bpat;
    logic [3:0] exp_t [9];
    // B glitches low on its third edge; A holds high
    bpat = 9'b110111111;
    exp_t = '{4'b0000, 4'b0000, 4'b0000, 4'b1010, 4'b1000, 4'b1000,
              4'b1101, 4'b1100, 4'b1100};
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      Ain = 1'b1; Bin = bpat[i];
      exp_q.push_back(exp_t[i]);
      @(posedge Clk); #1;
      got = {A, B, AChg, BChg}; want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL independence edge %0d got %b want %b", i + 1, got, want);
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_reset_mid_count();
    logic [3:0] got, want;
    do_reset(1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      Ain = 1'b1; Bin = 1'b0;
      exp_q.push_back(4'b0000);
      @(posedge Clk); #1;
      got = {A, B, AChg, BChg}; want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL midcount_pre edge %0d got %b want %b", i, got, want);
      end
      @(negedge Clk);
    end
    // Short reset pulse between edges discards the partial count
    Rst = 1'b1;
    #2;
    Rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      Ain = 1'b1; Bin = 1'b0;
      exp_q.push_back({i >= COMMIT, 1'b0, i == COMMIT, 1'b0});
      @(posedge Clk); #1;
      got = {A, B, AChg, BChg}; want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL midcount_post edge %0d got %b want %b", i, got, want);
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_long_hold();
    logic [3:0] got, want;
    do_reset(1'b0, 1'b0);
    // Long steady high: no wrap and no second pulse after the commit
    for (int i = 1; i <= 40; i++) begin
      Ain = 1'b0; Bin = 1'b1;
      exp_q.push_back({1'b0, i >= COMMIT, 1'b0, i == COMMIT});
      @(posedge Clk); #1;
      got = {A, B, AChg, BChg}; want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL long_hold edge %0d got %b want %b", i, got, want);
      end
      @(negedge Clk);
    end
  endtask

  initial begin
    Rst = 1'b1; Ain = 1'b0; Bin = 1'b0;
    @(negedge Clk);
    test_reset();
    test_reset_mid_count();
    test_long_hold();
`ifndef DEBOUNCE_SYNC_EN
    test_bounce();
    test_press_release();
    test_independence();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
